// File: rtl/mix_tree_sequencer.sv
// Load -> mix (leaf level to root) -> flush actuation sequencer for a bank of
// binary diffusion-mixing trees, started by a start/done handshake and abortable.
module mix_tree_sequencer #(
  parameter int DEPTH    = 2,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [CHANNELS-1:0]             chan_mask,
  input  logic [CNT_W-1:0]                load_cycles,
  input  logic [CNT_W-1:0]                mix_cycles,
  input  logic [CNT_W-1:0]                flush_cycles,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic [CHANNELS*(2**DEPTH)-1:0]  inlet_open,
  output logic [CHANNELS*DEPTH-1:0]       mix_en,
  output logic [CHANNELS-1:0]             outlet_open
);

  // state   | meaning
  // S_IDLE  | waiting for start with a non-empty channel mask
  // S_LOAD  | inlets of masked trees open for L cycles
  // S_MIX   | one mixer level enabled per M cycles, leaf level down to root
  // S_FLUSH | outlets of masked trees open for F cycles
  // S_FIN   | single done cycle, all valves closed

  localparam int INLETS = 2**DEPTH;
  localparam int LVL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(DEPTH-1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIX, S_FLUSH, S_FIN} state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [LVL_W-1:0]              r_level;
  logic [CHANNELS-1:0]           r_mask;
  logic [CNT_W-1:0]              r_mix_m1;
  logic [CNT_W-1:0]              r_flush_m1;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_aborted;
  logic [CHANNELS*INLETS-1:0]    r_inlet;
  logic [CHANNELS*DEPTH-1:0]     r_mix;
  logic [CHANNELS-1:0]           r_outlet;

  // Counter holds remaining cycles minus one; a zero duration collapses to one cycle.
  logic [CNT_W-1:0] w_load_m1, w_mix_m1, w_flush_m1;
  assign w_load_m1  = (load_cycles  == '0) ? '0 : load_cycles  - 1'b1;
  assign w_mix_m1   = (mix_cycles   == '0) ? '0 : mix_cycles   - 1'b1;
  assign w_flush_m1 = (flush_cycles == '0) ? '0 : flush_cycles - 1'b1;

  function automatic logic [CHANNELS*INLETS-1:0] f_inlets(input logic [CHANNELS-1:0] m);
    logic [CHANNELS*INLETS-1:0] v;
    v = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int i = 0; i < INLETS; i++)
        v[c*INLETS+i] = m[c];
    return v;
  endfunction

  function automatic logic [CHANNELS*DEPTH-1:0] f_mix(input logic [CHANNELS-1:0] m,
                                                      input logic [LVL_W-1:0] lvl);
    logic [CHANNELS*DEPTH-1:0] v;
    v = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int l = 0; l < DEPTH; l++)
        v[c*DEPTH+l] = m[c] && (l == int'(lvl));
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_level    <= '0;
      r_mask     <= '0;
      r_mix_m1   <= '0;
      r_flush_m1 <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_inlet    <= '0;
      r_mix      <= '0;
      r_outlet   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort && (chan_mask != '0)) begin
            r_state    <= S_LOAD;
            r_mask     <= chan_mask;
            r_mix_m1   <= w_mix_m1;
            r_flush_m1 <= w_flush_m1;
            r_cnt      <= w_load_m1;
            r_busy     <= 1'b1;
            r_inlet    <= f_inlets(chan_mask);
          end
        end
        S_LOAD, S_MIX, S_FLUSH: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
            r_inlet   <= '0;
            r_mix     <= '0;
            r_outlet  <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_state == S_LOAD) begin
            r_state <= S_MIX;
            r_level <= TOP_LVL;
            r_cnt   <= r_mix_m1;
            r_inlet <= '0;
            r_mix   <= f_mix(r_mask, TOP_LVL);
          end else if (r_state == S_MIX) begin
            if (r_level == '0) begin
              r_state  <= S_FLUSH;
              r_cnt    <= r_flush_m1;
              r_mix    <= '0;
              r_outlet <= r_mask;
            end else begin
              r_level <= r_level - 1'b1;
              r_cnt   <= r_mix_m1;
              r_mix   <= f_mix(r_mask, r_level - 1'b1);
            end
          end else begin
            r_state  <= S_FIN;
            r_outlet <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign inlet_open  = r_inlet;
  assign mix_en      = r_mix;
  assign outlet_open = r_outlet;

endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Scoreboarded bench: a table of runs for a 2-level/2-tree bank, hand-written
// reset and handshake corners, and a 3-level single-tree instance.
module tb_mix_tree_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] inlet;
    logic [3:0] mix;
    logic [1:0] outlet;
  } obs_t;

  typedef struct {
    logic [1:0] mask;
    int         l, m, f;
    int         abort_at;
    bit         perturb;
    int         exp_busy;
    bit         exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 0, abort = 0;
  logic [1:0] chan_mask = 0;
  logic [7:0] load_cycles = 0, mix_cycles = 0, flush_cycles = 0;
  logic       busy, done, aborted;
  logic [7:0] inlet_open;
  logic [3:0] mix_en;
  logic [1:0] outlet_open;

  logic       s1_start = 0, s1_abort = 0;
  logic [0:0] s1_mask = 0;
  logic [7:0] s1_load = 0, s1_mix = 0, s1_flush = 0;
  logic       s1_busy, s1_done, s1_aborted;
  logic [7:0] s1_inlet;
  logic [2:0] s1_mixen;
  logic [0:0] s1_outlet;

  mix_tree_sequencer #(.DEPTH(2), .CHANNELS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .chan_mask(chan_mask),
    .load_cycles(load_cycles), .mix_cycles(mix_cycles), .flush_cycles(flush_cycles),
    .busy(busy), .done(done), .aborted(aborted), .inlet_open(inlet_open),
    .mix_en(mix_en), .outlet_open(outlet_open));

  mix_tree_sequencer #(.DEPTH(3), .CHANNELS(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .abort(s1_abort), .chan_mask(s1_mask),
    .load_cycles(s1_load), .mix_cycles(s1_mix), .flush_cycles(s1_flush),
    .busy(s1_busy), .done(s1_done), .aborted(s1_aborted), .inlet_open(s1_inlet),
    .mix_en(s1_mixen), .outlet_open(s1_outlet));

  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];
  vec_t tbl[9];

  function automatic obs_t mk(logic b, logic d, logic a, logic [7:0] in,
                              logic [3:0] mx, logic [1:0] o);
    obs_t r;
    r.busy = b; r.done = d; r.aborted = a; r.inlet = in; r.mix = mx; r.outlet = o;
    return r;
  endfunction

  function automatic obs_t obs0();
    return mk(busy, done, aborted, inlet_open, mix_en, outlet_open);
  endfunction

  function automatic obs_t obs1();
    return mk(s1_busy, s1_done, s1_aborted, s1_inlet, {1'b0, s1_mixen}, {1'b0, s1_outlet});
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (busy,done,aborted,inlet,mix,outlet)", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference trace for the 2-level, 2-tree bank, one entry per cycle after the accept edge.
  task automatic build_trace(input vec_t v);
    obs_t full[$];
    int   lp, mp, fp, blen;
    logic [7:0] in_pat;
    logic [3:0] mx;
    if (v.mask == 2'b00) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
      return;
    end
    lp = (v.l == 0) ? 1 : v.l;
    mp = (v.m == 0) ? 1 : v.m;
    fp = (v.f == 0) ? 1 : v.f;
    blen = lp + 2*mp + fp;
    in_pat = {{4{v.mask[1]}}, {4{v.mask[0]}}};
    for (int i = 0; i < lp; i++) full.push_back(mk(1, 0, 0, in_pat, 4'b0, 2'b0));
    for (int lvl = 1; lvl >= 0; lvl--) begin
      mx = '0;
      for (int c = 0; c < 2; c++) mx[c*2+lvl] = v.mask[c];
      for (int i = 0; i < mp; i++) full.push_back(mk(1, 0, 0, 8'h0, mx, 2'b0));
    end
    for (int i = 0; i < fp; i++) full.push_back(mk(1, 0, 0, 8'h0, 4'b0, v.mask));
    if (v.abort_at >= 0 && v.abort_at < blen) begin
      for (int i = 0; i <= v.abort_at; i++) exp_q.push_back(full[i]);
      exp_q.push_back(mk(0, 0, 1, 8'h0, 4'b0, 2'b0));
    end else begin
      for (int i = 0; i < blen; i++) exp_q.push_back(full[i]);
      exp_q.push_back(mk(0, 1, 0, 8'h0, 4'b0, 2'b0));
    end
    exp_q.push_back('0);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int   n, busy_cnt, done_cnt;
    obs_t got;
    build_trace(v);
    n = exp_q.size();
    busy_cnt = 0;
    done_cnt = 0;
    chan_mask    = v.mask;
    load_cycles  = 8'(v.l);
    mix_cycles   = 8'(v.m);
    flush_cycles = 8'(v.f);
    start = 1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      got = obs0();
      check_obs($sformatf("vec%0d cyc%0d", k, i), got, exp_q.pop_front());
      busy_cnt += int'(got.busy);
      done_cnt += int'(got.done);
      start = 0;
      abort = (i == v.abort_at);
      if (v.perturb && i == 5) begin
        start = 1; mix_cycles = 8'd9; chan_mask = 2'b01; load_cycles = 8'd7; flush_cycles = 8'd0;
      end
      if (v.perturb && i == n-2) start = 1;
    end
    start = 0;
    abort = 0;
    check_int($sformatf("vec%0d busy_cycles", k), busy_cnt, v.exp_busy);
    check_int($sformatf("vec%0d done_pulses", k), done_cnt, int'(v.exp_done));
  endtask

  initial begin
    //          mask   L  M  F  abort pert busy done
    tbl[0] = '{2'b11, 3, 4, 2, -1, 0, 13, 1};
    tbl[1] = '{2'b10, 1, 1, 1, -1, 0,  4, 1};
    tbl[2] = '{2'b11, 0, 0, 0, -1, 0,  4, 1};
    tbl[3] = '{2'b00, 3, 3, 3, -1, 0,  0, 0};
    tbl[4] = '{2'b11, 3, 4, 2,  4, 0,  5, 0};
    tbl[5] = '{2'b01, 2, 3, 1, -1, 0,  9, 1};
    tbl[6] = '{2'b11, 3, 4, 2, -1, 1, 13, 1};
    tbl[7] = '{2'b01, 5, 1, 3,  8, 0,  9, 0};
    tbl[8] = '{2'b10, 1, 1, 1,  4, 0,  4, 1};

    @(negedge clk);
    check_obs("reset dut0", obs0(), '0);
    check_obs("reset dut1", obs1(), '0);
    rst = 0;

    for (int k = 0; k < 9; k++) run_vec(k, tbl[k]);

    // start together with abort in IDLE is ignored
    chan_mask = 2'b11; load_cycles = 8'd2; start = 1; abort = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_obs($sformatf("start_abort_idle cyc%0d", i), obs0(), '0);
    end
    start = 0; abort = 0;

    // async reset in the middle of LOAD, between clock edges, on both instances
    load_cycles = 8'd5; mix_cycles = 8'd2; flush_cycles = 8'd2; chan_mask = 2'b11;
    s1_mask = 1'b1; s1_load = 8'd5; s1_mix = 8'd1; s1_flush = 8'd1;
    start = 1; s1_start = 1;
    @(posedge clk); #1;
    start = 0; s1_start = 0;
    check_obs("pre_rst dut0 load", obs0(), mk(1, 0, 0, 8'hFF, 4'b0, 2'b0));
    @(posedge clk); #3;
    rst = 1;
    #1;
    check_obs("async_rst dut0", obs0(), '0);
    check_obs("async_rst dut1", obs1(), '0);
    @(posedge clk); #1;
    check_obs("rst_held dut0", obs0(), '0);
    @(negedge clk);
    rst = 0;
    run_vec(10, tbl[0]);

    // 3-level single tree: mix_en walks 100 -> 010 -> 001
    exp_q.push_back(mk(1, 0, 0, 8'hFF, 4'b0000, 2'b00));
    exp_q.push_back(mk(1, 0, 0, 8'h00, 4'b0100, 2'b00));
    exp_q.push_back(mk(1, 0, 0, 8'h00, 4'b0010, 2'b00));
    exp_q.push_back(mk(1, 0, 0, 8'h00, 4'b0001, 2'b00));
    exp_q.push_back(mk(1, 0, 0, 8'h00, 4'b0000, 2'b01));
    exp_q.push_back(mk(0, 1, 0, 8'h00, 4'b0000, 2'b00));
    exp_q.push_back('0);
    s1_mask = 1'b1; s1_load = 8'd1; s1_mix = 8'd1; s1_flush = 8'd1;
    s1_start = 1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      s1_start = 0;
      check_obs($sformatf("d3 cyc%0d", i), obs1(), exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_tree_sequencer.md
# mix_tree_sequencer

Cycle-accurate actuation sequencer for a parametrised bank of binary diffusion-mixing trees. It generalises the fixed two-level, two-root mixing tree to DEPTH levels and CHANNELS independent trees, driving inlet valves, per-level mixer enables and outlet valves through a load → mix (leaf level to root) → flush sequence. It sits between the protocol host and the valve-driver layer. Every run is started by a start/done handshake and can be aborted.

## Interface
Parameters:
- DEPTH, 2, mixer levels per tree (≥1); each tree has 2^DEPTH inlets
- CHANNELS, 2, number of independent trees (≥1)
- CNT_W, 8, width of the phase-duration inputs and the internal counter

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a run; sampled in IDLE only
- abort  in  1  cancel the run in progress
- chan_mask  in  CHANNELS  trees that take part in the run; latched at start accept
- load_cycles  in  CNT_W  inlet phase duration; latched at start accept
- mix_cycles  in  CNT_W  duration of each mix level; latched at start accept
- flush_cycles  in  CNT_W  outlet phase duration; latched at start accept
- busy  out  1  high from the first LOAD cycle through the last FLUSH cycle
- done  out  1  one-cycle pulse when a run completes normally
- aborted  out  1  one-cycle pulse when a run is cancelled
- inlet_open  out  CHANNELS*2^DEPTH  bit c*2^DEPTH+i drives inlet i of tree c
- mix_en  out  CHANNELS*DEPTH  bit c*DEPTH+l enables the level-l mixers of tree c (level 0 = root)
- outlet_open  out  CHANNELS  outlet valve of tree c

## Operation
- States: IDLE, LOAD, MIX, FLUSH, FIN.
- IDLE → LOAD when start=1, abort=0 and chan_mask≠0.
  - On that edge, latch the mask and the three durations. A latched duration of 0 is treated as 1.
  - start with chan_mask=0 is ignored: no busy, no done.
- LOAD: inlet_open has all 2^DEPTH bits set for each masked tree. Lasts L cycles, then → MIX at level DEPTH-1.
- MIX: mix_en is set for the current level of each masked tree only, one level at a time.
  - Each level lasts M cycles.
  - The level index steps from DEPTH-1 down to 0, then the state goes to FLUSH.
- FLUSH: outlet_open is set for the masked trees. Lasts F cycles, then → FIN.
- FIN: one cycle. done=1, busy=0, all valves closed. Then → IDLE.
- Outputs are registered and decoded from state only (Moore). Unmasked trees never see any bit asserted.
- start while not in IDLE is ignored. Input changes after the start accept have no effect on the current run.
- abort=1 in LOAD, MIX or FLUSH:
  - On the next edge, go to IDLE and close all valves.
  - busy=0 and aborted=1 for exactly one cycle. No done.
- abort in IDLE or FIN: no effect. FIN still pulses done.
- abort and start together in IDLE: start is ignored.
- The phase counter is CNT_W bits and reloads at each phase or level change. It never wraps in the middle of a phase.

## Timing
- Reset (async assert): state IDLE. All outputs 0: busy, done, aborted, inlet_open, mix_en, outlet_open. Latched registers cleared.
- Reset release is synchronous to the clock edge. The first start can be accepted on the first edge after rst deasserts.
- Reset asserted mid-run clears the outputs immediately, with no done and no aborted pulse.
- Start accepted at edge 0:
  - busy is high for L + DEPTH*M + F cycles, starting at edge 0.
  - done is high in the following cycle.
  - Back-to-back: a start on the done cycle is ignored (state is FIN). The earliest next accept is the cycle after done.
- Exactly one of inlet_open, mix_en or outlet_open is non-zero in any busy cycle. There is no overlap and no gap between phases.
- abort sampled at edge k: valves are 0 and aborted=1 in the cycle following edge k.

## Test plan
- Defaults; chan_mask=2'b11, L=3, M=4, F=2; pulse start.
  - inlet_open=8'hFF for 3 cycles.
  - mix_en=4'b1010 for 4 cycles, then 4'b0101 for 4 cycles.
  - outlet_open=2'b11 for 2 cycles.
  - busy high for 13 cycles, then done for 1 cycle.
- chan_mask=2'b10, L=M=F=1.
  - inlet_open=8'hF0, then mix_en=4'b1000, then 4'b0100, then outlet_open=2'b10.
  - Tree 0 bits are 0 throughout.
- L=0, M=0, F=0 → behaves as 1/1/1 (busy 4 cycles).
  - chan_mask=0 with start → busy and done stay 0.
- Assert abort in the 2nd MIX cycle.
  - Next cycle: all valves 0 and aborted=1 for 1 cycle; done never asserts.
  - A new start is then accepted normally.
- Pulse start during MIX and on the done cycle → both ignored.
  - Change mix_cycles mid-run → the level durations are unchanged.
- Assert rst asynchronously mid-LOAD, between clock edges → all outputs 0 immediately.
  - After release, a start runs a full sequence correctly.
  - Repeat with DEPTH=3, CHANNELS=1: mix_en steps 3'b100 → 3'b010 → 3'b001.
